// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side and system-bus-side signals of the sprite DMA block.
// The slave modport is the DMA/arbiter view; master is the surrounding system
// (CPU core plus bus decoder).
interface oam_dma_if;
  // CPU side
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic        cpu_rdy;
  // System bus side
  logic [7:0]  d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  // Status
  logic        dma_active;

  modport slave (
    input  cpu_addr,
    input  cpu_d_out,
    input  cpu_we,
    output cpu_rdy,
    input  d_in,
    output bus_addr,
    output bus_d_out,
    output bus_we,
    output dma_active
  );

  modport master (
    output cpu_addr,
    output cpu_d_out,
    output cpu_we,
    input  cpu_rdy,
    output d_in,
    input  bus_addr,
    input  bus_d_out,
    input  bus_we,
    input  dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: NES sprite DMA controller and system-bus arbiter.
// A CPU write to DMA_REG_ADDR stalls the CPU and copies 256 bytes from page
// {page, 8'h00} to OAM_DATA_ADDR as READ/WRITE pairs, then returns the bus.
// Optional feature macro: OAM_DMA_ALIGN_EN -- when defined, a free-running
// parity bit inserts one ALIGN cycle so every READ lands on an even cycle.
// Without it HALT always goes straight to READ (fixed 513-cycle stall).
// rst is asynchronous and active-low.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic      clk,
  input logic      rst,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;

  logic       trigger;
  logic       last_byte;

  // Output drivers, gathered locally then forwarded to the interface.
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_d_out_o;
  logic        bus_we_o;
  logic        cpu_rdy_o;
  logic        dma_active_o;

  // Only meaningful in IDLE; the next-state logic ignores it elsewhere, so a
  // stray write to the DMA register during a transfer has no effect.
  assign trigger   = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
  assign last_byte = (idx_q == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
  logic par_q;

  // Free-running cycle parity: 0 on even cycles, counted from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= ~par_q;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic for the FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          page_d  = bus.cpu_d_out;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // par_q==0 now means the next cycle is odd; burn it in ALIGN so the
        // first READ falls on an even cycle.
        state_d = par_q ? S_READ : S_ALIGN;
`else
        state_d = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: begin
        state_d = S_READ;
      end
`endif
      S_READ: begin
        data_d  = bus.d_in;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // idx wraps to 0 after 8'hFF; the source address never leaves the page.
        idx_d   = idx_q + 8'd1;
        state_d = last_byte ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and CPU-handshake outputs, decoded from the current state.
  always_comb begin
    bus_addr_o   = bus.cpu_addr;
    bus_d_out_o  = bus.cpu_d_out;
    bus_we_o     = 1'b0;
    cpu_rdy_o    = 1'b0;
    dma_active_o = 1'b1;
    case (state_q)
      S_IDLE: begin
        // Transparent pass-through; writes are suppressed while in reset.
        bus_we_o     = bus.cpu_we & rst;
        cpu_rdy_o    = 1'b1;
        dma_active_o = 1'b0;
      end
      S_READ: begin
        bus_addr_o = {page_q, idx_q};
      end
      S_WRITE: begin
        bus_addr_o  = OAM_DATA_ADDR;
        bus_d_out_o = data_q;
        bus_we_o    = 1'b1;
      end
      default: begin
        // HALT / ALIGN: CPU address visible, no write.
      end
    endcase
  end

  assign bus.bus_addr   = bus_addr_o;
  assign bus.bus_d_out  = bus_d_out_o;
  assign bus.bus_we     = bus_we_o;
  assign bus.cpu_rdy    = cpu_rdy_o;
  assign bus.dma_active = dma_active_o;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed, table-driven bench for oam_dma.
// Source memory model: byte at any address = addr[7:0] ^ 8'hA5.
module tb_oam_dma;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  oam_dma_if bus_if();

  oam_dma dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Combinational source memory, answering in the same cycle as bus_addr.
  assign bus_if.d_in = bus_if.bus_addr[7:0] ^ 8'hA5;

  // Reference cycle parity: 0 = even, toggles every clock from reset.
  logic tb_par;
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;
    logic        exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic cpu_idle();
    bus_if.cpu_addr  = 16'hC123;
    bus_if.cpu_d_out = 8'h00;
    bus_if.cpu_we    = 1'b0;
  endtask

  // Launch a transfer on a cycle of the requested parity and monitor the
  // whole stall, checking every READ/WRITE against the reference.
  task automatic run_dma(input logic [7:0] pg, input logic want_par, input bit glitch,
                         input string tag,
                         output logic [15:0] first_read, output logic [15:0] last_read);
    int   stall, writes, reads, guard, exp_stall;
    int   addr_err, data_err, par_err, gap_err, act_err, zero_hits;
    logic last_write;
    stall = 0; writes = 0; reads = 0; guard = 0;
    addr_err = 0; data_err = 0; par_err = 0; gap_err = 0; act_err = 0; zero_hits = 0;
    last_write = 1'b0;
    first_read = 16'hxxxx;
    last_read  = 16'hxxxx;

    @(negedge clk);
    while (tb_par !== want_par && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    bus_if.cpu_addr  = 16'h4014;
    bus_if.cpu_d_out = pg;
    bus_if.cpu_we    = 1'b1;
    #1;
    check({tag, "_trig_bus_addr"}, 32'(bus_if.bus_addr), 32'h4014);
    check({tag, "_trig_bus_we"},   32'(bus_if.bus_we), 32'h1);
    check({tag, "_trig_cpu_rdy"},  32'(bus_if.cpu_rdy), 32'h1);
`ifdef OAM_DMA_ALIGN_EN
    // The trigger cycle N has the same parity as N+2.
    exp_stall = (tb_par == 1'b0) ? 513 : 514;
`else
    exp_stall = 513;
`endif

    @(negedge clk);
    cpu_idle();
    #1;
    check({tag, "_halt_cpu_rdy"}, 32'(bus_if.cpu_rdy), 32'h0);

    while (bus_if.cpu_rdy === 1'b0 && stall < 700) begin
      stall++;
      if (bus_if.dma_active !== 1'b1) act_err++;
      if (bus_if.bus_addr === 16'h0000) zero_hits++;
      if (bus_if.bus_we === 1'b1) begin
        if (bus_if.bus_addr !== 16'h2004) addr_err++;
        if (bus_if.bus_d_out !== (writes[7:0] ^ 8'hA5)) data_err++;
`ifdef OAM_DMA_ALIGN_EN
        if (tb_par !== 1'b1) par_err++;
`endif
        if (writes != reads - 1) gap_err++;
        writes++;
        last_write = 1'b1;
      end else if (bus_if.bus_addr !== bus_if.cpu_addr) begin
        if (bus_if.bus_addr !== {pg, reads[7:0]}) addr_err++;
`ifdef OAM_DMA_ALIGN_EN
        if (tb_par !== 1'b0) par_err++;
`endif
        if (reads != writes) gap_err++;
        if (reads == 0) first_read = bus_if.bus_addr;
        last_read = bus_if.bus_addr;
        reads++;
        last_write = 1'b0;
      end else begin
        // HALT/ALIGN only allowed before copying begins.
        if (reads != 0) gap_err++;
        last_write = 1'b0;
      end
      @(negedge clk);
      if (glitch && stall == 100) begin
        bus_if.cpu_addr  = 16'h4014;
        bus_if.cpu_d_out = 8'h77;
        bus_if.cpu_we    = 1'b1;
      end else begin
        cpu_idle();
      end
      #1;
    end

    $display("%s: page=0x%0h stall=%0d reads=%0d writes=%0d", tag, pg, stall, reads, writes);
    check({tag, "_stall_len"},    32'(stall), 32'(exp_stall));
    check({tag, "_writes"},       32'(writes), 32'd256);
    check({tag, "_reads"},        32'(reads), 32'd256);
    check({tag, "_addr_errs"},    32'(addr_err), 32'd0);
    check({tag, "_data_errs"},    32'(data_err), 32'd0);
    check({tag, "_parity_errs"},  32'(par_err), 32'd0);
    check({tag, "_order_errs"},   32'(gap_err), 32'd0);
    check({tag, "_active_errs"},  32'(act_err), 32'd0);
    check({tag, "_addr0_hits"},   32'(zero_hits), 32'd0);
    check({tag, "_last_is_write"}, 32'(last_write), 32'h1);
    check({tag, "_end_active"},   32'(bus_if.dma_active), 32'h0);
    check({tag, "_end_bus_addr"}, 32'(bus_if.bus_addr), 32'hC123);
    check({tag, "_end_bus_we"},   32'(bus_if.bus_we), 32'h0);
  endtask

  initial begin
    logic [15:0] fr, lr;
    int          guard;
    bit          found;

    vecs[0] = '{16'h1234, 8'h00, 1'b0, 16'h1234, 8'h00, 1'b0};
    vecs[1] = '{16'h4015, 8'h5A, 1'b1, 16'h4015, 8'h5A, 1'b1};
    vecs[2] = '{16'h2004, 8'h3C, 1'b1, 16'h2004, 8'h3C, 1'b1};
    vecs[3] = '{16'h4014, 8'h11, 1'b0, 16'h4014, 8'h11, 1'b0};
    vecs[4] = '{16'h0000, 8'hFF, 1'b1, 16'h0000, 8'hFF, 1'b1};
    vecs[5] = '{16'hFFFF, 8'h80, 1'b0, 16'hFFFF, 8'h80, 1'b0};

    // Reset held with a CPU write on the bus.
    bus_if.cpu_addr  = 16'h1234;
    bus_if.cpu_d_out = 8'h00;
    bus_if.cpu_we    = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_addr",   32'(bus_if.bus_addr), 32'h1234);
    check("rst_bus_we",     32'(bus_if.bus_we), 32'h0);
    check("rst_cpu_rdy",    32'(bus_if.cpu_rdy), 32'h1);
    check("rst_dma_active", 32'(bus_if.dma_active), 32'h0);
    @(negedge clk);
    cpu_idle();
    rst = 1'b1;

    // Idle pass-through vectors; none may start a stall.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_if.cpu_addr  = vecs[i].addr;
      bus_if.cpu_d_out = vecs[i].dout;
      bus_if.cpu_we    = vecs[i].we;
      #1;
      check($sformatf("vec%0d_bus_addr", i),  32'(bus_if.bus_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_bus_d_out", i), 32'(bus_if.bus_d_out), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_bus_we", i),    32'(bus_if.bus_we), 32'(vecs[i].exp_we));
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_no_stall", i),  32'(bus_if.cpu_rdy), 32'h1);
      check($sformatf("vec%0d_inactive", i),  32'(bus_if.dma_active), 32'h0);
    end
    @(negedge clk);
    cpu_idle();

    // Even-aligned (513) then odd-aligned trigger (514 with alignment).
    run_dma(8'h02, 1'b0, 1'b0, "even", fr, lr);
    check("even_first_read", 32'(fr), 32'h0200);
    run_dma(8'h02, 1'b1, 1'b0, "odd", fr, lr);
    check("odd_first_read", 32'(fr), 32'h0200);

    // Top page: no wrap past 16'hFFFF.
    run_dma(8'hFF, 1'b1, 1'b0, "pageFF", fr, lr);
    check("pageFF_first_read", 32'(fr), 32'hFF00);
    check("pageFF_last_read",  32'(lr), 32'hFFFF);

    // Stray DMA-register write mid-transfer must be ignored.
    run_dma(8'h02, 1'b0, 1'b1, "glitch", fr, lr);
    check("glitch_last_read", 32'(lr), 32'h02FF);

    // Reset while reading idx 8'h40.
    @(negedge clk);
    bus_if.cpu_addr  = 16'h4014;
    bus_if.cpu_d_out = 8'h03;
    bus_if.cpu_we    = 1'b1;
    @(negedge clk);
    cpu_idle();
    #1;
    guard = 0;
    found = 1'b0;
    while (!found && guard < 300) begin
      if (bus_if.bus_we === 1'b0 && bus_if.bus_addr === 16'h0340) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
        #1;
        guard++;
      end
    end
    check("midrst_reached_idx40", 32'(found), 32'h1);
    rst = 1'b0;
    bus_if.cpu_addr = 16'h4014;
    bus_if.cpu_we   = 1'b1;
    #1;
    check("midrst_cpu_rdy",    32'(bus_if.cpu_rdy), 32'h1);
    check("midrst_bus_we",     32'(bus_if.bus_we), 32'h0);
    check("midrst_dma_active", 32'(bus_if.dma_active), 32'h0);
    check("midrst_bus_addr",   32'(bus_if.bus_addr), 32'h4014);
    repeat (2) @(negedge clk);
    cpu_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_resume_rdy",    32'(bus_if.cpu_rdy), 32'h1);
    check("midrst_no_resume_active", 32'(bus_if.dma_active), 32'h0);

    run_dma(8'h03, 1'b0, 1'b0, "restart", fr, lr);
    check("restart_first_read", 32'(fr), 32'h0300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
